// File: rtl/result_dma_engine.sv
// Drains result rows from the unified buffer onto a valid/ready write bus.
// Optional DMA_STALL_CNT_EN adds the stall_cycles back-pressure counter.
module result_dma_engine #(
  parameter int SYSTOLIC_ARRAY_WIDTH = 16,
  parameter int DATA_WIDTH_ACCUM     = 32,
  parameter int ADDR_WIDTH           = 10,
  parameter int RD_LATENCY           = 1,
  parameter int FIFO_DEPTH           = 4
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        start_pulse,
  input  logic [31:0]                                 dest_addr,
  input  logic [ADDR_WIDTH-1:0]                       src_addr,
  input  logic [15:0]                                 length,
  output logic                                        done_irq,
  output logic                                        busy,
  output logic [ADDR_WIDTH-1:0]                       core_rd_addr,
  output logic                                        core_rd_en,
  input  logic [SYSTOLIC_ARRAY_WIDTH*DATA_WIDTH_ACCUM-1:0] core_rd_data,
  output logic                                        bus_valid,
  input  logic                                        bus_ready,
  output logic [31:0]                                 bus_addr,
  output logic [SYSTOLIC_ARRAY_WIDTH*DATA_WIDTH_ACCUM-1:0] bus_data,
`ifdef DMA_STALL_CNT_EN
  output logic [31:0]                                 stall_cycles,
`endif
  output logic                                        bus_last
);

  localparam int          ROW_W      = SYSTOLIC_ARRAY_WIDTH * DATA_WIDTH_ACCUM;
  localparam logic [31:0] BEAT_BYTES = 32'(ROW_W / 8);
  localparam int          PTR_W      = $clog2(FIFO_DEPTH);
  localparam int          CNT_W      = PTR_W + 1;
  localparam int          SUM_W      = CNT_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                 r_state;
  logic [ADDR_WIDTH-1:0]  r_src;
  logic [31:0]            r_dest;
  logic [15:0]            r_len;
  logic [15:0]            r_issue_cnt;
  logic [15:0]            r_beat_cnt;
  logic [RD_LATENCY-1:0]  r_tag_p;
  logic [CNT_W-1:0]       r_inflight;
  logic [CNT_W-1:0]       r_count;
  logic [PTR_W-1:0]       r_wptr;
  logic [PTR_W-1:0]       r_rptr;
  logic [ROW_W-1:0]       r_mem [FIFO_DEPTH];

  logic                   w_push;
  logic                   w_empty;
  logic                   w_valid;
  logic                   w_pop;
  logic                   w_bypass;
  logic                   w_wr;
  logic                   w_rd;
  logic                   w_room;
  logic                   w_rd_en;
  logic                   w_last;
  logic                   w_accept;
  logic [ROW_W-1:0]       w_head;

  // Fall-through FIFO: a row arriving at an empty FIFO is presented on the bus
  // in the same cycle, and is not stored if the bus takes it immediately.
  assign w_push   = r_tag_p[RD_LATENCY-1];
  assign w_empty  = (r_count == '0);
  assign w_valid  = !w_empty || w_push;
  assign w_head   = w_empty ? core_rd_data : r_mem[r_rptr];
  assign w_pop    = w_valid && bus_ready;
  assign w_bypass = w_empty && w_push && w_pop;
  assign w_wr     = w_push && !w_bypass;
  assign w_rd     = w_pop && !w_empty;
  assign w_room   = (SUM_W'(r_count) + SUM_W'(r_inflight)) < SUM_W'(FIFO_DEPTH);
  assign w_rd_en  = (r_state == S_RUN) && w_room;
  assign w_last   = (r_beat_cnt == r_len - 16'd1);
  assign w_accept = (r_state == S_IDLE) && start_pulse;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_src       <= '0;
      r_dest      <= '0;
      r_len       <= '0;
      r_issue_cnt <= '0;
      r_beat_cnt  <= '0;
    end else begin
      if (w_rd_en) r_issue_cnt <= r_issue_cnt + 16'd1;
      if (w_pop)   r_beat_cnt  <= r_beat_cnt + 16'd1;
      case (r_state)
        S_IDLE: begin
          if (start_pulse) begin
            r_src       <= src_addr;
            r_dest      <= dest_addr;
            r_len       <= length;
            r_issue_cnt <= '0;
            r_beat_cnt  <= '0;
            // A zero-length command passes through DRAIN so done_irq lands two cycles out.
            r_state     <= (length != 16'd0) ? S_RUN : S_DRAIN;
          end
        end
        S_RUN: begin
          if (w_rd_en && (r_issue_cnt + 16'd1 == r_len)) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if ((w_pop && w_last) || (r_beat_cnt == r_len)) r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Read return path: tag shift register and FIFO bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag_p    <= '0;
      r_inflight <= '0;
      r_count    <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
    end else begin
      r_tag_p    <= (r_tag_p << 1) | RD_LATENCY'(w_rd_en);
      r_inflight <= r_inflight + CNT_W'(w_rd_en) - CNT_W'(w_push);
      r_count    <= r_count + CNT_W'(w_wr) - CNT_W'(w_rd);
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= core_rd_data;
  end

`ifdef DMA_STALL_CNT_EN
  logic [31:0] r_stall;
  always_ff @(posedge clk) begin
    if (rst || w_accept)                              r_stall <= '0;
    else if (w_valid && !bus_ready && r_stall != '1) r_stall <= r_stall + 32'd1;
  end
  assign stall_cycles = r_stall;
`endif

  // Outputs are zeroed when not qualified so idle values match reset values
  assign busy         = (r_state != S_IDLE);
  assign done_irq     = (r_state == S_DONE);
  assign core_rd_en   = w_rd_en;
  assign core_rd_addr = w_rd_en ? (r_src + ADDR_WIDTH'(r_issue_cnt)) : '0;
  assign bus_valid    = w_valid;
  assign bus_data     = w_valid ? w_head : '0;
  assign bus_addr     = w_valid ? (r_dest + 32'(r_beat_cnt) * BEAT_BYTES) : '0;
  assign bus_last     = w_valid && w_last;

endmodule

// File: tb/tb_result_dma_engine.sv
// Scoreboard bench for result_dma_engine: expected reads and beats are queued
// at command issue and retired as the DUT produces them.
module tb_result_dma_engine;

  localparam int ROW_W = 512;
  localparam int RDL   = 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              start_pulse;
  logic [31:0]       dest_addr;
  logic [9:0]        src_addr;
  logic [15:0]       length;
  logic              done_irq;
  logic              busy;
  logic [9:0]        core_rd_addr;
  logic              core_rd_en;
  logic [ROW_W-1:0]  core_rd_data;
  logic              bus_valid;
  logic              bus_ready;
  logic [31:0]       bus_addr;
  logic [ROW_W-1:0]  bus_data;
  logic              bus_last;
`ifdef DMA_STALL_CNT_EN
  logic [31:0]       stall_cycles;
`endif

  result_dma_engine #(
    .SYSTOLIC_ARRAY_WIDTH(16), .DATA_WIDTH_ACCUM(32), .ADDR_WIDTH(10),
    .RD_LATENCY(RDL), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .start_pulse(start_pulse), .dest_addr(dest_addr),
    .src_addr(src_addr), .length(length), .done_irq(done_irq), .busy(busy),
    .core_rd_addr(core_rd_addr), .core_rd_en(core_rd_en), .core_rd_data(core_rd_data),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_addr(bus_addr),
    .bus_data(bus_data),
`ifdef DMA_STALL_CNT_EN
    .stall_cycles(stall_cycles),
`endif
    .bus_last(bus_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]      addr;
    logic [ROW_W-1:0] data;
    logic             last;
  } beat_t;

  logic [9:0] rd_q[$];
  beat_t      beat_q[$];
  int         n_chk = 0;
  int         n_err = 0;
  int         done_cnt = 0;
  int         rd_cnt = 0;
  int         acc_cnt = 0;
  bit         len0_mode = 1'b0;

  function automatic logic [ROW_W-1:0] row(input logic [9:0] a);
    logic [ROW_W-1:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = {8'hA5, 8'(i), 6'd0, a};
    return r;
  endfunction

  // Core read port model with a registered row address
  logic [9:0] pa [RDL];
  always @(posedge clk) begin
    pa[0] <= core_rd_addr;
    for (int k = 1; k < RDL; k++) pa[k] <= pa[k-1];
  end
  assign core_rd_data = row(pa[RDL-1]);

  task automatic chk(input string tag, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic             prev_stall, prev_last, prev_done;
  logic [31:0]      prev_addr;
  logic [ROW_W-1:0] prev_data;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall <= 1'b0;
      prev_last  <= 1'b0;
      prev_done  <= 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", ROW_W'(bus_valid), ROW_W'(1));
        chk("hold_addr", ROW_W'(bus_addr), ROW_W'(prev_addr));
        chk("hold_data", bus_data, prev_data);
      end
      if (prev_done) chk("busy_drop", ROW_W'(busy), ROW_W'(0));
      if (core_rd_en) begin
        rd_cnt <= rd_cnt + 1;
        chk("rd_expected", ROW_W'(rd_q.size() != 0), ROW_W'(1));
        if (rd_q.size() != 0) begin
          chk("rd_addr", ROW_W'(core_rd_addr), ROW_W'(rd_q[0]));
          rd_q.delete(0);
        end
      end
      if (bus_valid && bus_ready) begin
        acc_cnt <= acc_cnt + 1;
        chk("beat_expected", ROW_W'(beat_q.size() != 0), ROW_W'(1));
        if (beat_q.size() != 0) begin
          chk("beat_addr", ROW_W'(bus_addr), ROW_W'(beat_q[0].addr));
          chk("beat_data", bus_data, beat_q[0].data);
          chk("beat_last", ROW_W'(bus_last), ROW_W'(beat_q[0].last));
          beat_q.delete(0);
        end
      end
      if (done_irq) begin
        done_cnt <= done_cnt + 1;
        if (!len0_mode) chk("done_after_last", ROW_W'(prev_last), ROW_W'(1));
      end
      prev_stall <= bus_valid && !bus_ready;
      prev_addr  <= bus_addr;
      prev_data  <= bus_data;
      prev_last  <= bus_valid && bus_ready && bus_last;
      prev_done  <= done_irq;
    end
  end

  task automatic start_cmd(input logic [9:0] s, input logic [31:0] d, input logic [15:0] n,
                           input bit accept);
    if (accept) begin
      for (int i = 0; i < int'(n); i++) begin
        logic [9:0] a;
        beat_t      b;
        a = s + 10'(i);
        rd_q.push_back(a);
        b.addr = d + 32'(i) * 32'd64;
        b.data = row(a);
        b.last = (i == int'(n) - 1);
        beat_q.push_back(b);
      end
    end
    src_addr    = s;
    dest_addr   = d;
    length      = n;
    start_pulse = 1'b1;
    tick();
    start_pulse = 1'b0;
    src_addr    = 10'($urandom);
    dest_addr   = $urandom;
    length      = 16'($urandom);
  endtask

  task automatic wait_done(input int d0, input int budget, input bit rnd);
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      if (rnd) bus_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    chk("done_seen", ROW_W'(done_cnt != d0), ROW_W'(1));
    bus_ready = 1'b1;
    repeat (4) tick();
    chk("done_once", ROW_W'(done_cnt - d0), ROW_W'(1));
    chk("rd_q_drained", ROW_W'(rd_q.size()), ROW_W'(0));
    chk("beat_q_drained", ROW_W'(beat_q.size()), ROW_W'(0));
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_done"}, ROW_W'(done_irq), ROW_W'(0));
    chk({tag, "_busy"}, ROW_W'(busy), ROW_W'(0));
    chk({tag, "_rd_en"}, ROW_W'(core_rd_en), ROW_W'(0));
    chk({tag, "_rd_addr"}, ROW_W'(core_rd_addr), ROW_W'(0));
    chk({tag, "_valid"}, ROW_W'(bus_valid), ROW_W'(0));
    chk({tag, "_last"}, ROW_W'(bus_last), ROW_W'(0));
    chk({tag, "_addr"}, ROW_W'(bus_addr), ROW_W'(0));
    chk({tag, "_data"}, bus_data, ROW_W'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int r0;
    int a0;
    rst = 1'b1; start_pulse = 1'b0; dest_addr = '0; src_addr = '0; length = '0;
    bus_ready = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk_idle_outputs("reset");
`ifdef DMA_STALL_CNT_EN
    chk("reset_stall", ROW_W'(stall_cycles), ROW_W'(0));
`endif
    rst = 1'b0;
    tick();

    // Basic 4-row transfer with latency checks
    d0 = done_cnt;
    start_cmd(10'h010, 32'h8000_0000, 16'd4, 1'b1);
    @(negedge clk);
    chk("t1_rd_c1", ROW_W'(core_rd_en), ROW_W'(1));
    chk("t1_valid_c1", ROW_W'(bus_valid), ROW_W'(0));
    chk("t1_busy_c1", ROW_W'(busy), ROW_W'(1));
    @(negedge clk);
    chk("t1_rd_c2", ROW_W'(core_rd_en), ROW_W'(1));
    chk("t1_valid_c2", ROW_W'(bus_valid), ROW_W'(1));
    wait_done(d0, 50, 1'b0);
`ifdef DMA_STALL_CNT_EN
    chk("t1_stall", ROW_W'(stall_cycles), ROW_W'(0));
`endif

    // 8 rows with the bus stalled for 20 valid cycles
    d0 = done_cnt;
    r0 = rd_cnt;
    bus_ready = 1'b0;
    start_cmd(10'h080, 32'h0000_1000, 16'd8, 1'b1);
    repeat (21) tick();
    chk("t2_outstanding", ROW_W'(rd_cnt - r0), ROW_W'(4));
    bus_ready = 1'b1;
    wait_done(d0, 100, 1'b0);
`ifdef DMA_STALL_CNT_EN
    chk("t2_stall", ROW_W'(stall_cycles), ROW_W'(20));
`endif

    // Source address wrap
    d0 = done_cnt;
    start_cmd(10'h3FE, 32'hFFFF_FF80, 16'd4, 1'b1);
    wait_done(d0, 50, 1'b0);

    // Zero-length command
    d0 = done_cnt;
    len0_mode = 1'b1;
    start_cmd(10'h123, 32'h0000_4000, 16'd0, 1'b1);
    @(negedge clk);
    chk("t4_busy_c1", ROW_W'(busy), ROW_W'(1));
    chk("t4_done_c1", ROW_W'(done_irq), ROW_W'(0));
    @(negedge clk);
    chk("t4_busy_c2", ROW_W'(busy), ROW_W'(1));
    chk("t4_done_c2", ROW_W'(done_irq), ROW_W'(1));
    @(negedge clk);
    chk("t4_busy_c3", ROW_W'(busy), ROW_W'(0));
    tick();
    len0_mode = 1'b0;
    chk("t4_done_count", ROW_W'(done_cnt - d0), ROW_W'(1));

    // Start while busy is ignored; random back-pressure
    d0 = done_cnt;
    start_cmd(10'h100, 32'h0000_1000, 16'd6, 1'b1);
    tick();
    start_cmd(10'h2AA, 32'h0000_5000, 16'd3, 1'b0);
    wait_done(d0, 200, 1'b1);

    // Reset after two accepted beats aborts silently
    d0 = done_cnt;
    a0 = acc_cnt;
    start_cmd(10'h040, 32'h0000_2000, 16'd6, 1'b1);
    for (int i = 0; i < 20 && (acc_cnt - a0) < 2; i++) tick();
    chk("t6_two_beats", ROW_W'(acc_cnt - a0), ROW_W'(2));
    bus_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk_idle_outputs("t6_abort");
    rd_q.delete();
    beat_q.delete();
    bus_ready = 1'b1;
    repeat (5) tick();
    chk("t6_no_done", ROW_W'(done_cnt - d0), ROW_W'(0));
    start_cmd(10'h200, 32'h0000_3000, 16'd2, 1'b1);
    wait_done(d0, 50, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
